// File: rtl/gate_tt_checker_if.sv
// A/B/Q stimulus-response bundle plus run control and result signals of the truth-table checker.
// The master side is the checker; the slave side is the gate under test and the controller.
interface gate_tt_checker_if;
    logic       start;
    logic       A;
    logic       B;
    logic       Q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [7:0] err_count;

    modport master (
        input  start,
        input  Q,
        output A,
        output B,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_count
    );

    modport slave (
        output start,
        output Q,
        input  A,
        input  B,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_count
    );
endinterface

// File: rtl/gate_tt_checker.sv
// Clocked truth-table checker: sweeps {A,B} through 00..11, samples Q after a settle window
// and accumulates a sticky per-vector failure mask, a saturating error count and a pass flag.
module gate_tt_checker #(
    parameter logic [3:0]  EXPECTED   = 4'b0001,
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned ITERATIONS = 1
) (
    input logic             clk,
    input logic             rst,
    gate_tt_checker_if.master bus
);

    localparam logic [7:0] SettleLast = 8'(SETTLE - 1);
    localparam logic [7:0] IterLast   = 8'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    state_e     state;
    logic [1:0] vec;
    logic [7:0] iter;
    logic [7:0] settle_cnt;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [7:0] err_count;

    logic       mismatch;
    logic [3:0] mask_next;

    // mask_next folds in the current sample so the final SAMPLE counts toward pass.
    always_comb begin
        mismatch  = (bus.Q != EXPECTED[vec]);
        mask_next = fail_mask;
        if (mismatch) begin
            mask_next[vec] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            vec        <= 2'd0;
            iter       <= 8'd0;
            settle_cnt <= 8'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= 4'd0;
            err_count  <= 8'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    a    <= 1'b0;
                    b    <= 1'b0;
                    busy <= 1'b0;
                    if (bus.start) begin
                        fail_mask  <= 4'd0;
                        err_count  <= 8'd0;
                        pass       <= 1'b0;
                        vec        <= 2'd0;
                        iter       <= 8'd0;
                        settle_cnt <= 8'd0;
                        busy       <= 1'b1;
                        state      <= StDrive;
                    end
                end
                StDrive: begin
                    if (settle_cnt == SettleLast) begin
                        settle_cnt <= 8'd0;
                        state      <= StSample;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                StSample: begin
                    fail_mask <= mask_next;
                    if (mismatch && err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    if (vec == 2'd3 && iter == IterLast) begin
                        a     <= 1'b0;
                        b     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mask_next == 4'd0);
                        state <= StDone;
                    end else begin
                        vec    <= vec + 2'd1;
                        {a, b} <= vec + 2'd1;
                        if (vec == 2'd3) begin
                            iter <= iter + 8'd1;
                        end
                        state <= StDrive;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.A         = a;
    assign bus.B         = b;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.fail_mask = fail_mask;
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: three parameterisations driven from a table of runs,
// plus hand-written mid-run reset and held-start sequences.
module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start_s = 3'b000;
    int         q_mode = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_tt_checker_if bus0 ();
    gate_tt_checker_if bus1 ();
    gate_tt_checker_if bus2 ();

    // 0: NOR gate, 1: Q tied 0, 2: Q tied 1, 3: OR gate
    function automatic logic gate_q(input int m, input logic a, input logic b);
        case (m)
            0:       return ~(a | b);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return a | b;
        endcase
    endfunction

    assign bus0.start = start_s[0];
    assign bus1.start = start_s[1];
    assign bus2.start = start_s[2];
    assign bus0.Q = gate_q(q_mode, bus0.A, bus0.B);
    assign bus1.Q = gate_q(q_mode, bus1.A, bus1.B);
    assign bus2.Q = gate_q(q_mode, bus2.A, bus2.B);

    gate_tt_checker dut0 (.clk(clk), .rst(rst), .bus(bus0));
    gate_tt_checker #(.EXPECTED(4'b0001), .SETTLE(1), .ITERATIONS(3))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    gate_tt_checker #(.EXPECTED(4'b0001), .SETTLE(1), .ITERATIONS(70))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [2:0] busy_v, done_v, pass_v;
    logic [1:0] ab_v   [3];
    logic [3:0] mask_v [3];
    logic [7:0] err_v  [3];
    int         settle [3] = '{2, 1, 1};

    assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
    assign done_v = {bus2.done, bus1.done, bus0.done};
    assign pass_v = {bus2.pass, bus1.pass, bus0.pass};
    assign ab_v[0] = {bus0.A, bus0.B};
    assign ab_v[1] = {bus1.A, bus1.B};
    assign ab_v[2] = {bus2.A, bus2.B};
    assign mask_v[0] = bus0.fail_mask;
    assign mask_v[1] = bus1.fail_mask;
    assign mask_v[2] = bus2.fail_mask;
    assign err_v[0] = bus0.err_count;
    assign err_v[1] = bus1.err_count;
    assign err_v[2] = bus2.err_count;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int         dut;
        int         qm;
        int         busy_cycles;
        logic       pass;
        logic [3:0] mask;
        int         err;
    } run_t;

    run_t runs[7];

    // Pulse start on one instance, trace busy/A/B/done, then compare the run result.
    task automatic do_run(input run_t r);
        int busy_n = 0;
        int done_n = 0;
        int ab_bad = 0;
        int done_busy = 0;
        int n = 0;
        logic [1:0] exp_ab;
        q_mode = r.qm;
        @(negedge clk);
        start_s[r.dut] = 1'b1;
        @(negedge clk);
        start_s[r.dut] = 1'b0;
        while (n < 3000 && !(done_n > 0 && !done_v[r.dut])) begin
            if (busy_v[r.dut]) begin
                exp_ab = 2'((busy_n / (settle[r.dut] + 1)) % 4);
                if (ab_v[r.dut] != exp_ab) ab_bad++;
                busy_n++;
            end
            if (done_v[r.dut]) begin
                done_n++;
                if (busy_v[r.dut]) done_busy++;
            end
            // A start pulse inside the run must be ignored.
            start_s[r.dut] = (busy_n == 3);
            @(negedge clk);
            n++;
        end
        start_s[r.dut] = 1'b0;
        check($sformatf("run%0d busy_cycles", r.dut), busy_n, r.busy_cycles);
        check($sformatf("run%0d done_pulses", r.dut), done_n, 1);
        check($sformatf("run%0d busy_at_done", r.dut), done_busy, 0);
        check($sformatf("run%0d ab_sequence_errs", r.dut), ab_bad, 0);
        check($sformatf("run%0d pass", r.dut), int'(pass_v[r.dut]), int'(r.pass));
        check($sformatf("run%0d fail_mask", r.dut), int'(mask_v[r.dut]), int'(r.mask));
        check($sformatf("run%0d err_count", r.dut), int'(err_v[r.dut]), r.err);
        repeat (3) @(negedge clk);
        check($sformatf("run%0d hold_result", r.dut),
              int'({pass_v[r.dut], mask_v[r.dut], err_v[r.dut]}),
              int'({r.pass, r.mask, 8'(r.err)}));
    endtask

    initial begin
        int n;
        int d1;
        int done_seen;

        runs[0] = '{0, 0, 12, 1'b1, 4'b0000, 0};
        runs[1] = '{0, 1, 12, 1'b0, 4'b0001, 1};
        runs[2] = '{0, 2, 12, 1'b0, 4'b1110, 3};
        runs[3] = '{1, 3, 24, 1'b0, 4'b1111, 12};
        runs[4] = '{2, 3, 560, 1'b0, 4'b1111, 255};
        runs[5] = '{0, 3, 12, 1'b0, 4'b1111, 4};
        runs[6] = '{1, 0, 24, 1'b1, 4'b0000, 0};

        repeat (3) @(negedge clk);
        check("reset ab_busy_done_pass", int'({ab_v[0], busy_v[0], done_v[0], pass_v[0]}), 0);
        check("reset mask_err", int'({mask_v[0], err_v[0]}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_run(runs[i]);
        end

        // Abort a Q-tied-1 run at vector 10 with an asynchronous reset.
        q_mode = 2;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        n = 0;
        while (n < 100 && ab_v[0] != 2'b10) begin
            @(negedge clk);
            n++;
        end
        check("abort reached_ab10", int'(ab_v[0]), 2);
        check("abort mask_before_reset", int'(mask_v[0]), 2);
        #2 rst = 1'b1;
        #1;
        check("abort outputs_cleared",
              int'({ab_v[0], busy_v[0], done_v[0], pass_v[0], mask_v[0], err_v[0]}), 0);
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_v[0]) done_seen++;
        end
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) done_seen++;
        end
        check("abort no_done_no_busy", done_seen, 0);
        do_run(runs[0]);

        // Start held high: back-to-back runs with one IDLE cycle after each done.
        q_mode = 0;
        @(negedge clk);
        start_s[0] = 1'b1;
        n = 0;
        done_seen = 0;
        d1 = 0;
        while (n < 200 && done_seen < 2) begin
            @(negedge clk);
            n++;
            if (done_v[0]) begin
                if (done_seen == 0) d1 = cyc;
                else check("held_start run_period", cyc - d1, 14);
                done_seen++;
            end
        end
        check("held_start done_count", done_seen, 2);
        @(negedge clk);
        check("held_start idle_after_done", int'(busy_v[0]), 0);
        @(negedge clk);
        check("held_start restarted", int'(busy_v[0]), 1);
        start_s[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("held_start final_pass", int'({pass_v[0], mask_v[0], err_v[0]}), 13'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Clocked truth-table checker for the 2-input basic gates (NOR, OR, NAND, AND, XOR). It is the stimulus/response end of a gate's A/B/Q interface. It drives A and B through all four input combinations, waits a settle window, samples Q and compares it against a parameterised expected truth table. It then reports pass/fail, a per-vector failure mask and an error count. It is used on-board and in simulation to self-test the gate library.

## Interface
Parameters:
- EXPECTED, 4'b0001: expected Q per vector index i = {A,B}; bit i is the expected value; default is the NOR truth table.
- SETTLE, 2: cycles A/B are held before Q is sampled; legal range 1..255.
- ITERATIONS, 1: number of full 4-vector sweeps per run; legal range 1..255.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled only in IDLE
- A  out  1  gate input A (registered)
- B  out  1  gate input B (registered)
- Q  in  1  gate output under test
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  run result, valid from done until next accepted start
- fail_mask  out  4  sticky; bit i set if any sample of vector i mismatched
- err_count  out  8  total mismatches in the run, saturates at 255

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - A=B=0, busy=0.
  - start=1 is accepted: clears fail_mask, err_count and pass; sets vector index i=0 and iteration count it=0.
  - Next state is DRIVE.
- DRIVE:
  - {A,B}=i, busy=1.
  - Settle counter runs 0..SETTLE-1.
  - After SETTLE cycles, go to SAMPLE.
- SAMPLE:
  - {A,B} is still held at i.
  - If Q != EXPECTED[i]: fail_mask[i] is set and err_count increments (saturating).
  - If i==3 and it==ITERATIONS-1, go to DONE.
  - Otherwise i=i+1 modulo 4; when i wraps 3->0, it increments. Go to DRIVE.
- DONE:
  - done=1 for exactly one cycle.
  - pass is registered as (fail_mask==0), including any update made in the final SAMPLE.
  - A=B=0, busy=0. Next state is IDLE.
- start is ignored in DRIVE, SAMPLE and DONE; it is not queued.
- The mismatch in the final SAMPLE cycle is included in fail_mask, err_count and pass.
- When err_count saturates at 255, later mismatches still update fail_mask.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - A=0, B=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0.
  - Counters go to 0.
  - A reset in the middle of a run aborts it with no done pulse.
- Accept:
  - The start cycle is edge T.
  - At T+1: busy=1 and {A,B}=00.
- Per vector: SETTLE DRIVE cycles plus 1 SAMPLE cycle = SETTLE+1 cycles. Q is sampled at the end of the SAMPLE cycle, which is SETTLE+1 edges after A/B changed.
- busy is high for exactly ITERATIONS*4*(SETTLE+1) cycles.
- done is asserted in the cycle after the last SAMPLE, with busy=0 in that cycle.
- The earliest new start is the cycle after done, in IDLE.
- The minimum run period is ITERATIONS*4*(SETTLE+1)+2 cycles, including the accept and DONE cycles.
- pass, fail_mask and err_count hold their values after done until the next start is accepted.
- All outputs are registered; there are no combinational paths from Q or start to any output.

## Test plan
- NOR model on A/B->Q, defaults (SETTLE=2, ITERATIONS=1), pulse start:
  - busy high 12 cycles, A/B sequence 00,01,10,11 with 3 cycles each.
  - done pulses once; pass=1, fail_mask=0000, err_count=0.
- Q tied 0, defaults: fail_mask=0001, err_count=1, pass=0.
- Q tied 1, defaults: fail_mask=1110, err_count=3, pass=0.
- OR model with EXPECTED=0001, ITERATIONS=3, SETTLE=1:
  - busy high 24 cycles.
  - fail_mask=1111, err_count=12, pass=0.
- Assert rst while A/B=10 mid-run:
  - All outputs reach their reset values immediately, with no done pulse.
  - A subsequent start runs a clean full sweep with the NOR model and reports pass=1.
- Hold start high continuously (NOR model, defaults):
  - Runs occur back-to-back with one IDLE cycle after each done.
  - Pulsing start during busy does not restart or extend the run.
